// File: rtl/hazard_stall_controller.sv
// Operand-forwarding selects, load-use stall/bubble and a mul/div stall FSM for the
// 5-stage pipe. Define HAZARD_PERF_CNT_EN to build the saturating stall_cycles counter.
module hazard_stall_controller #(
    parameter int INSTR_W    = 32,
    parameter int REG_AW     = 5,
    parameter int ERR_REG    = 30,
    parameter int RA_REG     = 31,
    parameter int MD_TIMEOUT = 40
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [INSTR_W-1:0] FD_instr,
    input  logic [INSTR_W-1:0] DX_instr,
    input  logic [INSTR_W-1:0] XM_instr,
    input  logic [INSTR_W-1:0] WB_instr,
    input  logic               XM_err,
    input  logic               WB_err,
    input  logic               md_ready,
    output logic [1:0]         fwd_a_sel,
    output logic [1:0]         fwd_b_sel,
    output logic               stall_fd,
    output logic               bubble_dx,
    output logic               stall_md,
    output logic               md_start,
    output logic               md_timeout,
    output logic [31:0]        stall_cycles,
    output logic [1:0]         o_dbg_md_state
);

    localparam int CNT_W = ((REG_AW + 1) > $clog2(MD_TIMEOUT + 1)) ?
                           (REG_AW + 1) : $clog2(MD_TIMEOUT + 1);
    localparam logic [REG_AW-1:0] ERR_R    = REG_AW'(ERR_REG);
    localparam logic [REG_AW-1:0] RA_R     = REG_AW'(RA_REG);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

    localparam logic [4:0] OP_RTYPE = 5'd0;
    localparam logic [4:0] OP_BNE   = 5'd2;
    localparam logic [4:0] OP_JAL   = 5'd3;
    localparam logic [4:0] OP_JR    = 5'd4;
    localparam logic [4:0] OP_ADDI  = 5'd5;
    localparam logic [4:0] OP_BLT   = 5'd6;
    localparam logic [4:0] OP_SW    = 5'd7;
    localparam logic [4:0] OP_LW    = 5'd8;
    localparam logic [4:0] OP_SETX  = 5'd21;
    localparam logic [4:0] OP_BEX   = 5'd22;
    localparam logic [4:0] ALU_MUL  = 5'd6;
    localparam logic [4:0] ALU_DIV  = 5'd7;

    typedef struct packed {
        logic              vld;
        logic [REG_AW-1:0] idx;
    } reg_ref_t;

    typedef struct packed {
        reg_ref_t a;
        reg_ref_t b;
    } read_set_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    function automatic logic [REG_AW-1:0] f_rd(input logic [INSTR_W-1:0] ins);
        return REG_AW'(ins[26:22]);
    endfunction

    function automatic logic [REG_AW-1:0] f_rs(input logic [INSTR_W-1:0] ins);
        return REG_AW'(ins[21:17]);
    endfunction

    function automatic logic [REG_AW-1:0] f_rt(input logic [INSTR_W-1:0] ins);
        return REG_AW'(ins[16:12]);
    endfunction

    function automatic read_set_t f_reads(input logic [INSTR_W-1:0] ins);
        read_set_t s;
        s = '0;
        case (ins[31:27])
            OP_RTYPE: begin
                s.a = {1'b1, f_rs(ins)};
                s.b = {1'b1, f_rt(ins)};
            end
            OP_ADDI, OP_LW: s.a = {1'b1, f_rs(ins)};
            OP_SW: begin
                s.a = {1'b1, f_rs(ins)};
                s.b = {1'b1, f_rd(ins)};
            end
            OP_BNE, OP_BLT: begin
                s.a = {1'b1, f_rd(ins)};
                s.b = {1'b1, f_rs(ins)};
            end
            OP_JR:   s.a = {1'b1, f_rd(ins)};
            OP_BEX:  s.a = {1'b1, ERR_R};
            default: s = '0;
        endcase
        return s;
    endfunction

    // Register 0 is hardwired, so a write to it never produces a hazard.
    function automatic reg_ref_t f_write(input logic [INSTR_W-1:0] ins);
        reg_ref_t w;
        w = '0;
        case (ins[31:27])
            OP_RTYPE, OP_ADDI, OP_LW: w = {1'b1, f_rd(ins)};
            OP_JAL:                   w = {1'b1, RA_R};
            OP_SETX:                  w = {1'b1, ERR_R};
            default:                  w = '0;
        endcase
        if (w.idx == '0) begin
            w.vld = 1'b0;
        end
        return w;
    endfunction

    function automatic logic [1:0] f_sel(input reg_ref_t opnd, input logic err,
                                         input reg_ref_t xm_w, input reg_ref_t wb_w);
        logic [1:0] sel;
        sel = 2'b00;
        if (opnd.vld) begin
            if (err && (opnd.idx == ERR_R)) begin
                sel = 2'b11;
            end else if (xm_w.vld && (xm_w.idx == opnd.idx)) begin
                sel = 2'b10;
            end else if (wb_w.vld && (wb_w.idx == opnd.idx)) begin
                sel = 2'b01;
            end
        end
        return sel;
    endfunction

    read_set_t         w_dx_reads;
    read_set_t         w_fd_reads;
    reg_ref_t          w_xm_wr;
    reg_ref_t          w_wb_wr;
    logic [REG_AW-1:0] w_dx_rd;
    logic              w_load_use;
    logic              w_dx_muldiv;

    assign w_dx_reads = f_reads(DX_instr);
    assign w_fd_reads = f_reads(FD_instr);
    assign w_xm_wr    = f_write(XM_instr);
    assign w_wb_wr    = f_write(WB_instr);
    assign w_dx_rd    = f_rd(DX_instr);

    assign fwd_a_sel = f_sel(w_dx_reads.a, XM_err | WB_err, w_xm_wr, w_wb_wr);
    assign fwd_b_sel = f_sel(w_dx_reads.b, XM_err | WB_err, w_xm_wr, w_wb_wr);

    assign w_load_use = (DX_instr[31:27] == OP_LW) && (w_dx_rd != '0) &&
                        ((w_fd_reads.a.vld && (w_fd_reads.a.idx == w_dx_rd)) ||
                         (w_fd_reads.b.vld && (w_fd_reads.b.idx == w_dx_rd)));

    assign w_dx_muldiv = (DX_instr[31:27] == OP_RTYPE) &&
                         ((DX_instr[6:2] == ALU_MUL) || (DX_instr[6:2] == ALU_DIV));

    // Handshake: md_start is a one-cycle request raised in IDLE when DX holds a
    // mul/div; md_ready is a one-cycle completion pulse honoured only in BUSY.
    md_state_t        r_md_state;
    md_state_t        w_md_state_next;
    logic [CNT_W-1:0] r_md_cnt;
    logic             r_md_timeout;
    logic             w_md_start;
    logic             w_stall_md;
    logic             w_cnt_clr;
    logic             w_cnt_inc;
    logic             w_to_set;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_md_state <= MD_IDLE;
        end else begin
            r_md_state <= w_md_state_next;
        end
    end

    always_comb begin
        w_md_state_next = r_md_state;
        w_md_start      = 1'b0;
        w_stall_md      = 1'b0;
        w_cnt_clr       = 1'b0;
        w_cnt_inc       = 1'b0;
        w_to_set        = 1'b0;
        case (r_md_state)
            MD_IDLE: begin
                if (w_dx_muldiv) begin
                    w_md_start      = 1'b1;
                    w_stall_md      = 1'b1;
                    w_cnt_clr       = 1'b1;
                    w_md_state_next = MD_BUSY;
                end
            end
            MD_BUSY: begin
                w_stall_md = 1'b1;
                w_cnt_inc  = 1'b1;
                // A ready pulse on the final allowed cycle wins over the timeout.
                if (md_ready) begin
                    w_md_state_next = MD_DONE;
                end else if (r_md_cnt == CNT_LAST) begin
                    w_md_state_next = MD_DONE;
                    w_to_set        = 1'b1;
                end
            end
            MD_DONE: begin
                w_md_state_next = MD_IDLE;
            end
            default: begin
                w_md_state_next = MD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_md_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_md_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_md_cnt <= r_md_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_md_timeout <= 1'b0;
        end else if (w_to_set) begin
            r_md_timeout <= 1'b1;
        end
    end

    assign md_start       = w_md_start;
    assign stall_md       = w_stall_md;
    assign md_timeout     = r_md_timeout;
    assign o_dbg_md_state = r_md_state;

    // A mul/div freeze already holds FD, so it also suppresses the load-use bubble.
    assign stall_fd  = w_load_use | w_stall_md;
    assign bubble_dx = w_load_use & ~w_stall_md;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if ((stall_fd | stall_md) && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller: directed forwarding, load-use and
// mul/div scenarios plus randomized instruction mixes against a rule-level model.
module tb_hazard_stall_controller;

  localparam int MD_TO = 40;

  logic        clock;
  logic        reset;
  logic [31:0] FD_instr, DX_instr, XM_instr, WB_instr;
  logic        XM_err, WB_err, md_ready;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        stall_fd, bubble_dx, stall_md, md_start, md_timeout;
  logic [31:0] stall_cycles;
  logic [1:0]  dbg_state;

  int          n_vec;
  int          n_err;
  int          exp_perf;
  logic        exp_to;

  hazard_stall_controller #(
    .INSTR_W(32), .REG_AW(5), .ERR_REG(30), .RA_REG(31), .MD_TIMEOUT(MD_TO)
  ) dut (
    .clock(clock), .reset(reset),
    .FD_instr(FD_instr), .DX_instr(DX_instr), .XM_instr(XM_instr), .WB_instr(WB_instr),
    .XM_err(XM_err), .WB_err(WB_err), .md_ready(md_ready),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_fd(stall_fd), .bubble_dx(bubble_dx), .stall_md(stall_md),
    .md_start(md_start), .md_timeout(md_timeout), .stall_cycles(stall_cycles),
    .o_dbg_md_state(dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  function automatic logic [31:0] mk(input int op, input int rd, input int rs,
                                     input int rt, input int alu);
    logic [31:0] v;
    v = '0;
    v[31:27] = op[4:0];
    v[26:22] = rd[4:0];
    v[21:17] = rs[4:0];
    v[16:12] = rt[4:0];
    v[6:2]   = alu[4:0];
    return v;
  endfunction

  // register read on port 0 (A) or 1 (B); -1 when the operand is not read
  function automatic int read_reg(input logic [31:0] ins, input int port);
    int op, rd, rs, rt, r;
    op = int'(ins[31:27]);
    rd = int'(ins[26:22]);
    rs = int'(ins[21:17]);
    rt = int'(ins[16:12]);
    r  = -1;
    if (port == 0) begin
      if (op == 0 || op == 5 || op == 7 || op == 8) r = rs;
      else if (op == 2 || op == 4 || op == 6) r = rd;
      else if (op == 22) r = 30;
    end else begin
      if (op == 0) r = rt;
      else if (op == 7) r = rd;
      else if (op == 2 || op == 6) r = rs;
    end
    return r;
  endfunction

  // register written (never 0); -1 when none
  function automatic int write_reg(input logic [31:0] ins);
    int op, r;
    op = int'(ins[31:27]);
    r  = -1;
    if (op == 0 || op == 5 || op == 8) r = int'(ins[26:22]);
    else if (op == 3) r = 31;
    else if (op == 21) r = 30;
    if (r == 0) r = -1;
    return r;
  endfunction

  function automatic logic [1:0] exp_sel(input logic [31:0] dx, input logic [31:0] xm,
                                         input logic [31:0] wb, input logic err, input int port);
    int r;
    r = read_reg(dx, port);
    if (r < 0) return 2'b00;
    if (err && r == 30) return 2'b11;
    if (write_reg(xm) == r) return 2'b10;
    if (write_reg(wb) == r) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic exp_lu(input logic [31:0] fd, input logic [31:0] dx);
    int rd;
    rd = int'(dx[26:22]);
    if (int'(dx[31:27]) != 8 || rd == 0) return 1'b0;
    return (read_reg(fd, 0) == rd) || (read_reg(fd, 1) == rd);
  endfunction

  function automatic logic [31:0] perf_exp();
`ifdef HAZARD_PERF_CNT_EN
    return 32'(exp_perf);
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] rnd_instr(input bit no_md);
    int ops[12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 21, 22};
    int regs[7] = '{0, 1, 2, 3, 5, 30, 31};
    int op, alu;
    logic [31:0] v;
    op  = ops[$urandom_range(0, 11)];
    alu = $urandom_range(0, 31);
    if (no_md && op == 0 && (alu == 6 || alu == 7)) alu = 0;
    v = mk(op, regs[$urandom_range(0, 6)], regs[$urandom_range(0, 6)],
           regs[$urandom_range(0, 6)], alu);
    v[11:7] = 5'($urandom_range(0, 31));
    v[1:0]  = 2'($urandom_range(0, 3));
    return v;
  endfunction

  // ---------------- scoreboard / driver tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic advance(input logic stalled);
    if (stalled && !reset) exp_perf++;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] fd, input logic [31:0] dx,
                       input logic [31:0] xm, input logic [31:0] wb,
                       input logic xe, input logic we);
    FD_instr = fd; DX_instr = dx; XM_instr = xm; WB_instr = wb;
    XM_err = xe; WB_err = we;
  endtask

  // mul/div run; n_ready < 1 means md_ready never arrives
  task automatic md_run(input int n_ready, input logic [31:0] md_ins, input bit inject_lu);
    int busy_exp, n_stall, n_start;
    logic to_hit;
    to_hit   = !(n_ready >= 1 && n_ready <= MD_TO);
    busy_exp = to_hit ? MD_TO : n_ready;
    n_stall  = 0;
    n_start  = 0;
    DX_instr = md_ins;
    FD_instr = '0;
    md_ready = 1'b0;
    @(negedge clock);
    check("md_go_start", md_start, 1);
    check("md_go_stall", stall_md, 1);
    check("md_go_stall_fd", stall_fd, 1);
    n_stall += int'(stall_md);
    n_start += int'(md_start);
    advance(1'b1);
    for (int k = 1; k <= busy_exp; k++) begin
      md_ready = (k == n_ready);
      if (inject_lu && k == 2) begin
        DX_instr = mk(8, 5, 1, 0, 0);
        FD_instr = mk(0, 6, 5, 2, 0);
      end else begin
        DX_instr = md_ins;
        FD_instr = '0;
      end
      @(negedge clock);
      check("md_busy_stall", stall_md, 1);
      check("md_busy_start", md_start, 0);
      check("md_busy_stall_fd", stall_fd, 1);
      check("md_busy_bubble", bubble_dx, 0);
      check("md_busy_to", md_timeout, exp_to);
      n_stall += int'(stall_md);
      n_start += int'(md_start);
      advance(1'b1);
    end
    if (to_hit) exp_to = 1'b1;
    DX_instr = md_ins;
    FD_instr = '0;
    md_ready = 1'b1;
    @(negedge clock);
    check("md_done_stall", stall_md, 0);
    check("md_done_start", md_start, 0);
    check("md_done_stall_fd", stall_fd, 0);
    check("md_done_to", md_timeout, exp_to);
    check("md_done_perf", stall_cycles, perf_exp());
    n_stall += int'(stall_md);
    n_start += int'(md_start);
    advance(1'b0);
    md_ready = 1'b0;
    DX_instr = '0;
    @(negedge clock);
    check("md_idle_start", md_start, 0);
    check("md_idle_stall", stall_md, 0);
    n_start += int'(md_start);
    check("md_stall_len", 32'(n_stall), 32'(busy_exp + 1));
    check("md_start_count", 32'(n_start), 32'd1);
    advance(1'b0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] fd, dx, xm, wb;
    logic        xe, we, lu;
    n_vec = 0; n_err = 0; exp_perf = 0; exp_to = 1'b0;
    reset = 1'b1;
    md_ready = 1'b0;
    drive('0, '0, '0, '0, 1'b0, 1'b0);
    @(negedge clock);
    check("rst_stall_md", stall_md, 0);
    check("rst_md_start", md_start, 0);
    check("rst_md_to", md_timeout, 0);
    check("rst_perf", stall_cycles, 0);
    check("rst_fwd_a", fwd_a_sel, 0);
    check("rst_stall_fd", stall_fd, 0);
    @(posedge clock);
    #1 reset = 1'b0;

    // add r3,r1,r2 producer; sub r4,r3,r3 consumer
    drive('0, mk(0, 4, 3, 3, 1), mk(0, 3, 1, 2, 0), '0, 1'b0, 1'b0);
    @(negedge clock);
    check("fwd_xm_a", fwd_a_sel, 2'b10);
    check("fwd_xm_b", fwd_b_sel, 2'b10);
    advance(1'b0);
    drive('0, mk(0, 4, 3, 3, 1), '0, mk(0, 3, 1, 2, 0), 1'b0, 1'b0);
    @(negedge clock);
    check("fwd_wb_a", fwd_a_sel, 2'b01);
    check("fwd_wb_b", fwd_b_sel, 2'b01);
    advance(1'b0);
    drive('0, mk(0, 4, 0, 0, 1), mk(0, 0, 1, 2, 0), mk(0, 0, 1, 2, 0), 1'b0, 1'b0);
    @(negedge clock);
    check("fwd_r0_a", fwd_a_sel, 2'b00);
    check("fwd_r0_b", fwd_b_sel, 2'b00);
    advance(1'b0);

    // lw r5,0(r1) in DX, add r6,r5,r2 in FD
    drive(mk(0, 6, 5, 2, 0), mk(8, 5, 1, 0, 0), '0, '0, 1'b0, 1'b0);
    @(negedge clock);
    check("lu_stall_fd", stall_fd, 1);
    check("lu_bubble", bubble_dx, 1);
    advance(1'b1);
    drive(mk(0, 6, 5, 2, 0), '0, mk(8, 5, 1, 0, 0), '0, 1'b0, 1'b0);
    @(negedge clock);
    check("lu_after_stall_fd", stall_fd, 0);
    check("lu_after_bubble", bubble_dx, 0);
    advance(1'b0);
    drive(mk(0, 6, 0, 2, 0), mk(8, 0, 1, 0, 0), '0, '0, 1'b0, 1'b0);
    @(negedge clock);
    check("lu_r0_stall_fd", stall_fd, 0);
    advance(1'b0);

    // exception register override
    drive('0, mk(22, 0, 0, 0, 0), mk(0, 7, 1, 1, 0), '0, 1'b1, 1'b0);
    @(negedge clock);
    check("bex_err_a", fwd_a_sel, 2'b11);
    advance(1'b0);
    drive('0, mk(22, 0, 0, 0, 0), mk(21, 5, 0, 0, 0), '0, 1'b0, 1'b0);
    @(negedge clock);
    check("bex_setx_a", fwd_a_sel, 2'b10);
    advance(1'b0);
    drive('0, mk(22, 0, 0, 0, 0), mk(21, 5, 0, 0, 0), '0, 1'b0, 1'b1);
    @(negedge clock);
    check("bex_wberr_a", fwd_a_sel, 2'b11);
    advance(1'b0);

    // randomized mixes with the FSM idle
    for (int i = 0; i < 300; i++) begin
      fd = rnd_instr(1'b0);
      dx = rnd_instr(1'b1);
      xm = rnd_instr(1'b0);
      wb = rnd_instr(1'b0);
      xe = ($urandom_range(0, 3) == 0);
      we = ($urandom_range(0, 3) == 0);
      drive(fd, dx, xm, wb, xe, we);
      md_ready = 1'($urandom_range(0, 1));
      lu = exp_lu(fd, dx);
      @(negedge clock);
      check("rnd_fwd_a", fwd_a_sel, exp_sel(dx, xm, wb, xe | we, 0));
      check("rnd_fwd_b", fwd_b_sel, exp_sel(dx, xm, wb, xe | we, 1));
      check("rnd_stall_fd", stall_fd, lu);
      check("rnd_bubble", bubble_dx, lu);
      check("rnd_stall_md", stall_md, 0);
      check("rnd_md_start", md_start, 0);
      check("rnd_md_to", md_timeout, exp_to);
      check("rnd_perf", stall_cycles, perf_exp());
      advance(lu);
    end
    md_ready = 1'b0;
    drive('0, '0, '0, '0, 1'b0, 1'b0);

    // mul with ready 32 cycles after start, plus a load-use overlap mid-BUSY
    md_run(32, mk(0, 3, 1, 2, 6), 1'b1);
    for (int i = 0; i < 4; i++) begin
      md_run($urandom_range(1, MD_TO + 5),
             mk(0, $urandom_range(1, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                6 + $urandom_range(0, 1)), 1'b0);
    end
    md_run(MD_TO, mk(0, 4, 1, 2, 7), 1'b0);
    md_run(-1, mk(0, 4, 1, 2, 7), 1'b0);
    check("to_sticky", md_timeout, 1);

    // second div, reset asserted mid-BUSY
    DX_instr = mk(0, 9, 1, 2, 7);
    advance(1'b1);
    for (int k = 0; k < 5; k++) advance(1'b1);
    #1 reset = 1'b1;
    exp_perf = 0;
    exp_to   = 1'b0;
    #1;
    check("rst_mid_to", md_timeout, 0);
    check("rst_mid_perf", stall_cycles, 0);
    check("rst_mid_start", md_start, 1);
    check("rst_mid_stall", stall_md, 1);
    DX_instr = '0;
    #1;
    check("rst_mid_idle_stall", stall_md, 0);
    @(posedge clock);
    #1 reset = 1'b0;

    // 10-cycle load-use stall run
    drive(mk(0, 6, 5, 2, 0), mk(8, 5, 1, 0, 0), '0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      check("perf_run_stall", stall_fd, 1);
      advance(1'b1);
    end
    drive('0, '0, '0, '0, 1'b0, 1'b0);
    @(negedge clock);
    check("perf_10", stall_cycles, perf_exp());
    check("final_to", md_timeout, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
